// File: rtl/rst_seq_pkg.sv
// Shared types, default parameters and sizing helper for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_GAP_CYCLES  = 4;
    localparam int DEF_NUM_OUT     = 3;

    // Wide enough to hold the larger of the hold and gap periods without wrapping.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int longest;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES rising edges.
module rst_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    // NOTE: non-blocking assignments make every stage sample the previous stage's old value, so the chain shifts by exactly one stage per edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staggered reset release sequencer with async assert / sync deassert.
// Optional macro SOFT_RST_EN adds the soft_rst_req port and the DONE->HOLD restart.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int NUM_OUT     = DEF_NUM_OUT
) (
    input  logic               clk,
    input  logic               reset,
`ifdef SOFT_RST_EN
    input  logic               soft_rst_req,
`endif
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done,
    output logic               busy
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             sync_out;

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk     (clk),
        .reset   (reset),
        .sync_out(sync_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                // The synchronizer output rises on E0, so the first edge that
                // sees it high is already the first hold tick: ASSERT then acts
                // exactly like HOLD with the counter at zero.
                ASSERT, HOLD: begin
                    if (state == HOLD || sync_out) begin
                        if (cnt == HOLD_LAST) begin
                            rst_out_n[0] <= 1'b1;
                            cnt          <= '0;
                            if (NUM_OUT == 1) begin
                                state    <= DONE;
                                rst_done <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                state <= RELEASE;
                                idx   <= IDX_W'(1);
                            end
                        end else begin
                            state <= HOLD;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        rst_out_n[idx] <= 1'b1;
                        cnt            <= '0;
                        if (idx == IDX_LAST) begin
                            state    <= DONE;
                            rst_done <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
`ifdef SOFT_RST_EN
                    // Soft restart reuses the already-synchronized release and goes straight to HOLD.
                    if (soft_rst_req) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        idx       <= '0;
                        rst_out_n <= '0;
                        rst_done  <= 1'b0;
                        busy      <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= ASSERT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected per-edge outputs are queued, then popped each cycle.
module tb_rst_seq_ctrl;

    localparam int SYNC    = 2;
    localparam int HOLD    = 16;
    localparam int GAP     = 4;
    localparam int NUM_OUT = 3;

    typedef struct packed {
        logic [NUM_OUT-1:0] rst;
        logic               done;
        logic               busy;
    } exp_t;

    logic               clk    = 1'b0;
    logic               clk_en = 1'b1;
    logic               reset  = 1'b1;
`ifdef SOFT_RST_EN
    logic               soft_rst_req = 1'b0;
`endif
    logic [NUM_OUT-1:0] rst_out_n;
    logic               rst_done;
    logic               busy;

    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    rst_seq_ctrl #(
        .SYNC_STAGES(SYNC),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .NUM_OUT    (NUM_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef SOFT_RST_EN
        .soft_rst_req(soft_rst_req),
`endif
        .rst_out_n   (rst_out_n),
        .rst_done    (rst_done),
        .busy        (busy)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    // Expected outputs right after edge n of a sequence whose E0 is edge e0.
    function automatic exp_t model(input int n, input int e0);
        exp_t e;
        for (int i = 0; i < NUM_OUT; i++) begin
            e.rst[i] = (n >= e0 + HOLD + i * GAP);
        end
        e.done = (n >= e0 + HOLD + (NUM_OUT - 1) * GAP);
        e.busy = !e.done;
        return e;
    endfunction

    task automatic push_schedule(input int first, input int last, input int e0);
        for (int n = first; n <= last; n++) sb.push_back(model(n, e0));
    endtask

    task automatic test_reset;
        exp_t obs;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        obs = {rst_out_n, rst_done, busy};
        total++;
        if (obs !== {{NUM_OUT{1'b0}}, 1'b0, 1'b1})
            $display("FAIL reset_async: got rst_out_n=%b rst_done=%b busy=%b, want 000 0 1", rst_out_n, rst_done, busy);
        else
            passed++;
        for (int n = 1; n <= 5; n++) sb.push_back('{rst: '0, done: 1'b0, busy: 1'b1});
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL reset_hold edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
    endtask

    task automatic test_power_on;
        @(negedge clk);
        reset = 1'b1;
        push_schedule(1, 30, SYNC);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e, obs;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL power_on edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
    endtask

    task automatic test_async_abort;
        exp_t obs;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_schedule(1, 10, SYNC);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL abort_pre edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
        // Freeze the clock low, then abort mid-HOLD.
        @(negedge clk);
        clk_en = 1'b0;
        #3 reset = 1'b0;
        #1;
        obs = {rst_out_n, rst_done, busy};
        total++;
        if (obs !== {{NUM_OUT{1'b0}}, 1'b0, 1'b1})
            $display("FAIL abort_noclk: got rst_out_n=%b rst_done=%b busy=%b, want 000 0 1", rst_out_n, rst_done, busy);
        else
            passed++;
        #1 reset = 1'b1;
        #1 clk_en = 1'b1;
        push_schedule(1, 30, SYNC);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL abort_rerun edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
    endtask

    task automatic test_glitch;
        exp_t obs;
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        obs = {rst_out_n, rst_done, busy};
        total++;
        if (obs !== {{NUM_OUT{1'b0}}, 1'b0, 1'b1})
            $display("FAIL glitch_drop: got rst_out_n=%b rst_done=%b busy=%b, want 000 0 1", rst_out_n, rst_done, busy);
        else
            passed++;
        push_schedule(1, 30, SYNC);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL glitch_rerun edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
    endtask

    // Continues from edge 30 of the previous sequence: DONE must hold with no restart.
    task automatic test_done_stable;
        push_schedule(31, 50, SYNC);
        for (int n = 31; sb.size() > 0; n++) begin
            exp_t e, obs;
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL done_stable edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
    endtask

`ifdef SOFT_RST_EN
    task automatic test_soft_reset;
        push_schedule(1, 28, 1);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e, obs;
            @(negedge clk);
            soft_rst_req = (n == 1);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL soft_reset edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
        soft_rst_req = 1'b0;
    endtask

    // Request held from reset release through RELEASE is ignored; once DONE
    // is reached with it still high, exactly one soft restart happens (edge 27).
    task automatic test_ignored_request;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_schedule(1, 26, SYNC);
        push_schedule(27, 52, 27);
        for (int n = 1; sb.size() > 0; n++) begin
            exp_t e, obs;
            @(negedge clk);
            soft_rst_req = (n <= 27);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {rst_out_n, rst_done, busy};
            total++;
            if (obs !== e)
                $display("FAIL ignored_req edge %0d: got %b %b %b, want %b %b %b", n, rst_out_n, rst_done, busy, e.rst, e.done, e.busy);
            else
                passed++;
        end
        soft_rst_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_power_on();
        test_async_abort();
        test_glitch();
        test_done_stable();
`ifdef SOFT_RST_EN
        test_soft_reset();
        test_ignored_request();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
